// File: rtl/ppacc_pkg.sv
// ppacc_pkg: shared state encoding and default geometry for the partial-product accumulator
package ppacc_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} ppacc_state_t;
  localparam int PPACC_NPP   = 24;
  localparam int PPACC_WIDTH = 48;
  localparam int PPACC_PPC   = 4;
  localparam int PPACC_NGRP  = PPACC_NPP / PPACC_PPC;
endpackage

// File: rtl/ppacc_grpadd.sv
// ppacc_grpadd: combinational sum of PPC partial products plus the running accumulator
// Ports: pp (PPC slices, slice k = pp[k*WIDTH +: WIDTH]), acc (running sum), sum (acc + all slices, mod 2^WIDTH)
module ppacc_grpadd import ppacc_pkg::*; #(
  parameter int WIDTH = PPACC_WIDTH,
  parameter int PPC   = PPACC_PPC
) (
  input  logic [PPC*WIDTH-1:0] pp,
  input  logic [WIDTH-1:0]     acc,
  output logic [WIDTH-1:0]     sum
);
  logic [WIDTH-1:0] s, c, x, t;
  // Carry-save reduction keeps one redundant (s, c) pair; a single carry-propagate add resolves it.
  always_comb begin
    s = acc;
    c = '0;
    x = '0;
    t = '0;
    for (int k = 0; k < PPC; k++) begin
      x = pp[k*WIDTH +: WIDTH];
      t = s ^ c ^ x;
      c = ((s & c) | (s & x) | (c & x)) << 1;
      s = t;
    end
    sum = s + c;
  end
endmodule

// File: rtl/ppacc.sv
// ppacc: multi-cycle partial-product accumulator, PPC slices summed per cycle into one product
// Ports: clk_i, rst_i (sync, active-high); in_valid_i/in_ready_o/pp_i accept an NPP*WIDTH array;
//        out_valid_o/out_ready_i/prod_o deliver the WIDTH-bit product; busy_o flags accumulation.
// Option: define PPACC_EARLY_EXIT_EN to stop accumulating once the remaining groups are all zero.
module ppacc import ppacc_pkg::*; #(
  parameter int NPP   = PPACC_NPP,
  parameter int WIDTH = PPACC_WIDTH,
  parameter int PPC   = PPACC_PPC
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [NPP*WIDTH-1:0] pp_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     prod_o,
  output logic                 busy_o
);
  localparam int NGRP = NPP / PPC;
  localparam int IW   = NGRP > 1 ? $clog2(NGRP) : 1;
  ppacc_state_t state, nxt;
  logic [NPP*WIDTH-1:0] pp_q;
  logic [WIDTH-1:0] acc_q, sum;
  logic [IW-1:0] idx;
  logic accept, last;
  assign accept = in_valid_i && state == IDLE;
`ifdef PPACC_EARLY_EXIT_EN
  // zt_d[g]: every slice after group g is zero, so group g is the last one worth adding.
  logic [NGRP-1:0] zt_d, zt_q;
  for (genvar g = 0; g < NGRP; g++) begin : g_tail
    if (g == NGRP - 1) begin : g_end
      assign zt_d[g] = 1'b1;
    end else begin : g_mid
      assign zt_d[g] = ~|pp_i[NPP*WIDTH-1 : (g+1)*PPC*WIDTH];
    end
  end
  always_ff @(posedge clk_i)
    if (rst_i) zt_q <= '0;
    else if (accept) zt_q <= zt_d;
  assign last = idx == IW'(NGRP - 1) || zt_q[idx];
`else
  assign last = idx == IW'(NGRP - 1);
`endif
  ppacc_grpadd #(.WIDTH(WIDTH), .PPC(PPC)) u_grpadd (
    .pp  (pp_q[idx*PPC*WIDTH +: PPC*WIDTH]),
    .acc (acc_q),
    .sum (sum)
  );
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (in_valid_i ? ACC : IDLE)
        : state == ACC  ? (last ? DONE : ACC)
        : (out_ready_i ? IDLE : DONE);
  always_comb begin
    in_ready_o  = state == IDLE && !rst_i;
    out_valid_o = state == DONE;
    busy_o      = state == ACC;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      acc_q <= '0;
      idx   <= '0;
    end else if (accept) begin
      pp_q  <= pp_i;
      acc_q <= '0;
      idx   <= '0;
    end else if (state == ACC) begin
      acc_q <= sum;
      idx   <= idx + IW'(1);
    end
  assign prod_o = acc_q;
endmodule

// File: tb/tb_ppacc.sv
// tb_ppacc: self-checking bench for ppacc (vector table, hand sequences, randomized multiplies)
module tb_ppacc;
  localparam int NPP = 24, W = 48, PPC = 4, NGRP = 6;
`ifdef PPACC_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [NPP*W-1:0] pp = '0;
  logic [W-1:0] prod;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  ppacc dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .pp_i(pp),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .prod_o(prod), .busy_o(busy)
  );
  typedef struct {
    string       nm;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [47:0] want;
    int          lat_early;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask
  // Partial products of an unsigned 24x24 multiply: slice j = ma << j when bit j of mb is set.
  function automatic logic [NPP*W-1:0] mkpp(input logic [23:0] ma, input logic [23:0] mb);
    logic [NPP*W-1:0] r = '0;
    for (int j = 0; j < NPP; j++) r[j*W +: W] = mb[j] ? (48'(ma) << j) : 48'd0;
    return r;
  endfunction
  // Edges spent accumulating: all groups, or with early exit up to the last group holding a non-zero slice.
  function automatic int model_lat(input logic [23:0] ma, input logic [23:0] mb);
    int hi = -1;
    for (int j = 0; j < NPP; j++) if (mb[j] && ma != 0) hi = j;
    if (!EE) return NGRP;
    return hi < 0 ? 1 : hi / PPC + 1;
  endfunction
  task automatic run(input string nm, input logic [23:0] ma, input logic [23:0] mb,
                     input logic [47:0] want, input int lat, input int stall);
    int n = 0;
    @(negedge clk);
    chk({nm, " in_ready"}, in_ready, 1);
    pp = mkpp(ma, mb);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    pp = {36{$urandom()}};
    chk({nm, " busy"}, busy, 1);
    while (!out_valid && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " prod"}, prod, want);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, " stall prod"}, prod, want);
      chk({nm, " stall valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " valid drop"}, out_valid, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [23:0] ma, mb;
    logic [47:0] wa, wb;
    int n, nov, nacc, rise, acc2;
    bit prev_ov, acc_last, bad;
    tbl[0] = '{"single_bit", 24'h800000, 24'h800000, 48'h400000000000, 6};
    tbl[1] = '{"max",        24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 6};
    tbl[2] = '{"slice0",     24'h000001, 24'h000001, 48'h1,            1};
    tbl[3] = '{"three_five", 24'h000003, 24'h000005, 48'hF,            1};
    tbl[4] = '{"zero",       24'h000000, 24'h000000, 48'h0,            1};
    tbl[5] = '{"grp1",       24'h123456, 24'h000010, 48'h1234560,      2};
    tbl[6] = '{"grp5",       24'h000001, 24'h100000, 48'h100000,       6};
    tbl[7] = '{"grp3",       24'h000ABC, 24'h001000, 48'hABC000,       4};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset prod", prod, 0);
    rst = 1'b0;
    #1 chk("post reset in_ready", in_ready, 1);
    foreach (tbl[i]) run(tbl[i].nm, tbl[i].ma, tbl[i].mb, tbl[i].want, EE ? tbl[i].lat_early : NGRP, 0);
    // Backpressure with in_valid held: DONE must hold and refuse new data until the handshake.
    wa = 48'hFFFFFE000001;
    wb = 48'd15;
    @(negedge clk);
    pp = mkpp(24'hFFFFFF, 24'hFFFFFF);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pp = mkpp(24'd3, 24'd5);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    for (int s = 0; s < 3; s++) begin
      if (s > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      chk("bp valid", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
      chk("bp busy", busy, 0);
      chk("bp prod", prod, wa);
    end
    @(posedge clk);
    @(negedge clk);
    chk("bp 4th valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp handshake valid", out_valid, 0);
    chk("bp idle in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("bp second prod", prod, wb);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    // Reset on the third ACC edge discards the product.
    pp = mkpp(24'hFFFFFF, 24'hFFFFFF);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst mid in_ready", in_ready, 0);
    chk("rst mid busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("rst mid out_valid", out_valid, 0);
    chk("rst mid prod", prod, 0);
    chk("rst mid in_ready after", in_ready, 1);
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("rst mid no valid pulse", bad, 0);
    run("after_rst", 24'd3, 24'd5, 48'd15, model_lat(24'd3, 24'd5), 0);
    // Back-to-back: second acceptance two edges after the first out_valid rises.
    wa = 48'h400000000000;
    ma = 24'($urandom());
    mb = 24'($urandom());
    wb = 48'(ma) * 48'(mb);
    @(negedge clk);
    pp = mkpp(24'h800000, 24'h800000);
    in_valid = 1'b1;
    out_ready = 1'b1;
    nov = 0;
    nacc = 0;
    rise = -1;
    acc2 = -1;
    prev_ov = 1'b0;
    acc_last = 1'b0;
    for (int k = 0; k < 80 && nov < 2; k++) begin
      if (k > 0) @(negedge clk);
      if (acc_last) pp = mkpp(ma, mb);
      acc_last = 1'b0;
      if (out_valid && !prev_ov) begin
        nov++;
        if (nov == 1) rise = cyc;
        chk(nov == 1 ? "b2b first prod" : "b2b second prod", prod, nov == 1 ? wa : wb);
      end
      prev_ov = out_valid;
      if (nacc >= 2) in_valid = 1'b0;
      else if (in_ready && in_valid) begin
        nacc++;
        acc_last = 1'b1;
        if (nacc == 2) acc2 = cyc + 1;
      end
    end
    chk("b2b products seen", nov, 2);
    chk("b2b accept gap", acc2 - rise, 2);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    // Randomized multiplies with varying top-bit position of mb and random output stalls.
    for (int i = 0; i < 30; i++) begin
      ma = 24'($urandom());
      mb = 24'($urandom()) & (24'hFFFFFF >> $urandom_range(0, 23));
      run("random", ma, mb, 48'(ma) * 48'(mb), model_lat(ma, mb), $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
